// File: rtl/sdram_copy_dma.sv
// sdram_copy_dma
//   Copies num_words words from src_addr to dest_addr through one Avalon-MM
//   master port. Reads are pipelined into a small read-data FIFO. Writes drain
//   that FIFO on the same port. When both kinds of command are possible, they
//   alternate.
//
// Ports
//   clk, rst_n               clock (rising edge) and asynchronous active-low reset
//   enable                   start request, sampled only while idle
//   src_addr, dest_addr      byte addresses, latched at start
//   num_words                transfer length in words, latched at start
//   copying                  high while the copy is running
//   done                     one-cycle pulse after the last write is accepted
//   master_*                 Avalon-MM master (address/read/write/writedata out,
//                            waitrequest/readdata/readdatavalid in)
module sdram_copy_dma #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              copying,
  output logic              done,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
  localparam logic [SUM_W-1:0]  DEPTH_C   = SUM_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic                copying_q;
  logic                done_q;
  logic                rd_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]    rd_left_q, rd_left_d;
  logic [CNT_W-1:0]    wr_left_q, wr_left_d;
  logic [OCC_W-1:0]    inflight_q, inflight_d;
  logic [OCC_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic                last_wr_q, last_wr_d;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];

  logic                rd_acc;
  logic                wr_acc;
  logic                push;
  logic                hold;
  logic [SUM_W-1:0]    occ_sum;
  logic                rd_elig;
  logic                wr_elig;
  logic                pick_rd;
  logic                pick_wr;
  logic [DATA_W-1:0]   head;

  assign copying          = copying_q;
  assign done             = done_q;
  assign master_read      = rd_q;
  assign master_write     = wr_q;
  assign master_address   = addr_q;
  assign master_writedata = wdata_q;

  // Datapath next-state. Arbitration looks at the post-accept values, so a
  // new command can be issued on the edge that retires the previous one.
  always_comb begin
    rd_acc = rd_q & ~master_waitrequest;
    wr_acc = wr_q & ~master_waitrequest;
    hold   = (rd_q | wr_q) & master_waitrequest;
    // Stray responses (idle, or nothing outstanding) are dropped.
    push   = master_readdatavalid & (state_q == ST_RUN) & (inflight_q != '0);

    inflight_d = inflight_q;
    if (rd_acc && !push) begin
      inflight_d = inflight_q + OCC_ONE;
    end else if (!rd_acc && push) begin
      inflight_d = inflight_q - OCC_ONE;
    end

    count_d = count_q;
    if (push && !wr_acc) begin
      count_d = count_q + OCC_ONE;
    end else if (!push && wr_acc) begin
      count_d = count_q - OCC_ONE;
    end

    rd_left_d = rd_acc ? (rd_left_q - CNT_ONE) : rd_left_q;
    wr_left_d = wr_acc ? (wr_left_q - CNT_ONE) : wr_left_q;
    rd_addr_d = rd_acc ? (rd_addr_q + ADDR_STEP) : rd_addr_q;
    wr_addr_d = wr_acc ? (wr_addr_q + ADDR_STEP) : wr_addr_q;
    rptr_d    = wr_acc ? (rptr_q + PTR_ONE) : rptr_q;
    wptr_d    = push ? (wptr_q + PTR_ONE) : wptr_q;

    last_wr_d = last_wr_q;
    if (wr_acc) begin
      last_wr_d = 1'b1;
    end else if (rd_acc) begin
      last_wr_d = 1'b0;
    end

    // Credit rule: reserve a FIFO slot for every read still in flight.
    occ_sum = SUM_W'(count_d) + SUM_W'(inflight_d);
    rd_elig = (rd_left_d != '0) && (occ_sum < DEPTH_C);
    wr_elig = (count_d != '0);
    pick_wr = wr_elig && (!rd_elig || !last_wr_d);
    pick_rd = rd_elig && !pick_wr;

    // New FIFO head: if the stored entries are all being popped, the word
    // arriving this cycle becomes the head and is taken straight from the bus.
    if (count_q == OCC_W'(wr_acc)) begin
      head = master_readdata;
    end else begin
      head = mem[rptr_d];
    end
  end

  // Read-data buffer storage.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= master_readdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      copying_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      last_wr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          if (enable) begin
            state_q   <= ST_RUN;
            copying_q <= 1'b1;
            rd_addr_q <= src_addr;
            wr_addr_q <= dest_addr;
            rd_left_q <= num_words;
            wr_left_q <= num_words;
            // Treat the start as if a write had just retired, so a read goes first.
            last_wr_q <= 1'b1;
          end
        end

        ST_RUN: begin
          rd_addr_q  <= rd_addr_d;
          wr_addr_q  <= wr_addr_d;
          rd_left_q  <= rd_left_d;
          wr_left_q  <= wr_left_d;
          inflight_q <= inflight_d;
          count_q    <= count_d;
          rptr_q     <= rptr_d;
          wptr_q     <= wptr_d;
          last_wr_q  <= last_wr_d;
          if (wr_left_d == '0) begin
            // Last write retired (or the copy was empty).
            state_q   <= ST_DONE;
            copying_q <= 1'b0;
            done_q    <= 1'b1;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
          end else if (!hold) begin
            rd_q <= pick_rd;
            wr_q <= pick_wr;
            if (pick_rd) begin
              addr_q <= rd_addr_d;
            end else if (pick_wr) begin
              addr_q  <= wr_addr_d;
              wdata_q <= head;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q   <= ST_IDLE;
          copying_q <= 1'b0;
          done_q    <= 1'b0;
          rd_q      <= 1'b0;
          wr_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
